biphase_rx_framer: RTL
======================

Name: biphase_rx_framer

Overview:
- Receive-side link controller sitting directly after the biphase-to-NRZ decoder in the console receive path.
- Consumes the decoder's per-bit strobes (data, bit valid, framing error, glitch) and runs a link state machine (hunt/sync, idle, data, stop).
- Assembles async-style frames (start 0, DATA_BITS LSB-first, stop 1) into bytes and delivers them over a valid/ready interface.
- Tracks link health and drops the link on repeated errors or line silence.

Parameters:
- DATA_BITS, 8: data bits per frame.
- SYNC_ONES, 10: consecutive 1 bits required in HUNT to declare link up.
- ERR_LIMIT, 4: consecutive frame-level errors that force HUNT.
- IDLE_TIMEOUT, 2000: clk cycles without bit_valid (outside HUNT) that force HUNT.
- CNT_W, 16: width of the saturating statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- bit_valid  in  1  one-cycle strobe per decoded bit (decoder data_received).
- bit_data  in  1  NRZ bit value, valid with bit_valid.
- framing_error  in  1  one-cycle decoder framing-error strobe.
- glitch_ignored  in  1  one-cycle decoder glitch strobe.
- rx_data  out  DATA_BITS  received byte.
- rx_valid  out  1  rx_data holds an undelivered byte.
- rx_ready  in  1  consumer accepts rx_data.
- link_up  out  1  high in IDLE/DATA/STOP/PARITY.
- overrun  out  1  one-cycle pulse: completed byte dropped because the buffer was full.
- parity_error  out  1  one-cycle pulse (optional feature only).
- err_count  out  CNT_W  saturating total of frame-level errors.
- glitch_count  out  CNT_W  saturating total of glitch_ignored strobes.

Behaviour:
- Reset (rst==0 at clk edge):
  - state=HUNT; all outputs 0; rx_data=0.
  - ones counter, bit index, shift register, consecutive-error counter and timeout counter = 0.
- Input priority in one cycle: framing_error dominates. A bit_valid in the same cycle is discarded. glitch_ignored is only counted, and is counted even when framing_error is also asserted.
- HUNT:
  - bit_valid with bit_data=1: ones++.
  - bit_data=0 or framing_error: ones=0.
  - When ones reaches SYNC_ONES: go to IDLE, clear consecutive errors, clear timeout counter. link_up rises the cycle after the SYNC_ONES-th 1.
- IDLE:
  - Bit 1: stay.
  - Bit 0 (start bit): bit index=0, go to DATA.
- DATA: each bit shifts in LSB-first. After the DATA_BITS-th bit, go to STOP (or PARITY when the optional feature is enabled).
- STOP:
  - Bit 1: good frame; consecutive errors=0; deliver byte; go to IDLE.
  - Bit 0: frame error; byte discarded; go to IDLE.
- Frame error (bad stop, decoder framing_error in any non-HUNT state, parity mismatch):
  - err_count++ (saturates at all-ones), consecutive errors++.
  - If consecutive errors reach ERR_LIMIT: go to HUNT, ones=0. Otherwise go to IDLE, aborting any partial frame.
- framing_error in HUNT: resets ones only; not counted in err_count.
- Timeout:
  - Counter clears on every bit_valid or framing_error and increments otherwise; it saturates at IDLE_TIMEOUT.
  - On reaching IDLE_TIMEOUT in a non-HUNT state: go to HUNT. This is not counted as an error.
- Output buffer: one entry.
  - Delivery happens the cycle after the stop-bit bit_valid: rx_data loaded, rx_valid=1.
  - rx_valid&&rx_ready clears rx_valid unless a new byte loads in the same cycle; in that case the new byte loads and rx_valid stays 1.
  - If rx_valid&&!rx_ready when a byte completes: new byte dropped, rx_data unchanged, overrun pulses 1 cycle.
  - rx_data is stable while rx_valid&&!rx_ready.
  - The buffer is unaffected by HUNT entry; a pending byte stays deliverable.
- Mid-operation reset: returns to reset state within that cycle, discarding any buffered byte.

Optional Feature:
- Macro BIPHASE_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA. It expects even parity over data+parity bit.
  - Mismatch: parity_error pulses 1 cycle, frame error handling applies, go to IDLE without checking stop.
  - Match: go to STOP.
- Undefined: no PARITY state; DATA goes directly to STOP; parity_error tied 0.

Test Plan:
- Sync: 9 ones then 0 -> link_up stays 0, ones reset. Then 10 ones -> link_up=1 the cycle after the 10th bit.
- Byte: after sync, send 0, bits of 0xA5 LSB-first, 1 -> rx_data=0xA5, rx_valid=1 one cycle after the stop strobe; rx_ready=1 clears it next cycle.
- Backpressure: rx_ready=0, send 0x3C then 0x7E -> rx_data stays 0x3C, overrun pulses once at 0x7E completion. Repeat with rx_ready asserted in the completion cycle -> 0x7E loads, no overrun.
- Errors: 4 consecutive frames with stop=0 -> err_count=4, link_up falls after the 4th. With 3 bad frames then 1 good, consecutive errors clear and link stays up.
- Priority/timeout:
  - framing_error and bit_valid together mid-byte -> bit ignored, err_count+1, state IDLE.
  - After sync, no bits for 2000 cycles -> link_up=0.
  - 5 glitch strobes -> glitch_count=5.
- Parity (BIPHASE_RX_PARITY_EN): 0x01 with parity bit 0 -> parity_error pulse, no rx_valid, err_count+1. With parity bit 1 -> rx_data=0x01 delivered.

Source files
------------

// File: rtl/biphase_rx_framer.sv
// Receive framer behind the biphase decoder: link hunt/sync, async frame assembly, 1-entry output buffer.
// Optional even-parity stage is enabled by defining BIPHASE_RX_PARITY_EN.
module biphase_rx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int SYNC_ONES    = 10,
  parameter int ERR_LIMIT    = 4,
  parameter int IDLE_TIMEOUT = 2000,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 bit_data,
  input  logic                 framing_error,
  input  logic                 glitch_ignored,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 link_up,
  output logic                 overrun,
  output logic                 parity_error,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     glitch_count
);

  localparam int ONES_W = $clog2(SYNC_ONES + 1);
  localparam int IDX_W  = $clog2(DATA_BITS + 1);
  localparam int CONS_W = $clog2(ERR_LIMIT + 1);
  localparam int TMO_W  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    HUNT   = 3'd0,
    IDLE   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [ONES_W-1:0]    ones, ones_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [CONS_W-1:0]    consec, consec_nxt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic                 line_quiet;
  logic                 tmo_hit;
  logic                 frame_err;
  logic                 good_frame;
`ifdef BIPHASE_RX_PARITY_EN
  logic                 par_err;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign link_up    = (state != HUNT);
  assign line_quiet = !bit_valid && !framing_error;
  // The counter holds the number of quiet cycles already seen, so this edge is the limit-th one.
  assign tmo_hit    = line_quiet && (tmo_cnt >= TMO_W'(IDLE_TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    ones_nxt   = ones;
    idx_nxt    = idx;
    shift_nxt  = shift_reg;
    consec_nxt = consec;
    frame_err  = 1'b0;
    good_frame = 1'b0;
`ifdef BIPHASE_RX_PARITY_EN
    par_err    = 1'b0;
`endif
    if (state == HUNT) begin
      if (framing_error || (bit_valid && !bit_data)) begin
        ones_nxt = '0;
      end else if (bit_valid) begin
        if (ones == ONES_W'(SYNC_ONES - 1)) begin
          state_nxt  = IDLE;
          ones_nxt   = '0;
          consec_nxt = '0;
        end else begin
          ones_nxt = ones + 1'b1;
        end
      end
    end else if (framing_error) begin
      frame_err = 1'b1;
    end else if (tmo_hit) begin
      state_nxt = HUNT;
      ones_nxt  = '0;
    end else if (bit_valid) begin
      case (state)
        IDLE: begin
          if (!bit_data) begin
            idx_nxt   = '0;
            state_nxt = DATA;
          end
        end
        DATA: begin
          shift_nxt = {bit_data, shift_reg[DATA_BITS-1:1]};
          if (idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef BIPHASE_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
`ifdef BIPHASE_RX_PARITY_EN
        PARITY: begin
          if ((^shift_reg) ^ bit_data) begin
            par_err   = 1'b1;
            frame_err = 1'b1;
          end else begin
            state_nxt = STOP;
          end
        end
`endif
        STOP: begin
          if (bit_data) begin
            good_frame = 1'b1;
            consec_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            frame_err = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // Any frame-level error aborts the partial frame; enough in a row drops the link.
    if (frame_err) begin
      consec_nxt = consec + 1'b1;
      if (consec >= CONS_W'(ERR_LIMIT - 1)) begin
        state_nxt = HUNT;
        ones_nxt  = '0;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      ones      <= '0;
      idx       <= '0;
      shift_reg <= '0;
      consec    <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ones      <= ones_nxt;
      idx       <= idx_nxt;
      shift_reg <= shift_nxt;
      consec    <= consec_nxt;
      if (!line_quiet) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_W'(IDLE_TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  // Output buffer: a completed byte lands the cycle after its stop bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (good_frame && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else begin
        if (good_frame) begin
          overrun <= 1'b1;
        end
        if (rx_valid && rx_ready) begin
          rx_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count    <= '0;
      glitch_count <= '0;
    end else begin
      if (frame_err) begin
        err_count <= sat_inc(err_count);
      end
      if (glitch_ignored) begin
        glitch_count <= sat_inc(glitch_count);
      end
    end
  end

`ifdef BIPHASE_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_error <= 1'b0;
    end else begin
      parity_error <= par_err;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
